hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Drives stall and flush controls for the IF/ID and ID/EX buffers, including the bubble insertion into ID/EX, and EX-stage forwarding selects.
- Owns the halt sequence that freezes the pipeline once a stop instruction retires.
- Keeps saturating stall and flush cycle counters for debug.

Parameters:
CNT_W, 16, width of the stall/flush performance counters.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rsD  in  5  ID source register rs
rtD  in  5  ID source register rt
useRsD  in  1  ID instruction reads rs
useRtD  in  1  ID instruction reads rt
isBranchD  in  1  ID holds a branch that compares its operands in ID
PCSrcD  in  1  branch taken or jump resolved in ID
rsE  in  5  EX source register rs
rtE  in  5  EX source register rt
rwE  in  5  EX destination register
RegWriteE  in  1  EX instruction writes the register file
MemtoRegE  in  1  EX instruction is a load
rwM  in  5  MEM destination register
RegWriteM  in  1  MEM instruction writes the register file
MemtoRegM  in  1  MEM instruction is a load
rwW  in  5  WB destination register
RegWriteW  in  1  WB instruction writes the register file
StopW  in  1  stop instruction is retiring in WB
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
FlushD  out  1  clear IF/ID
FlushE  out  1  insert bubble into ID/EX
isLWHazard  out  1  load-use stall active this cycle
ForwardAE  out  2  EX operand A select: 00 register file, 10 MEM, 01 WB
ForwardBE  out  2  EX operand B select: 00 register file, 10 MEM, 01 WB
ForwardAD  out  1  ID branch operand A taken from MEM
ForwardBD  out  1  ID branch operand B taken from MEM
halted  out  1  pipeline frozen
stall_cnt  out  CNT_W  cycles with StallD=1
flush_cnt  out  CNT_W  cycles with FlushD=1

Behaviour:
- Register 0 never matches. Every match term below requires the relevant destination register to be nonzero.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM and rwM==rsE.
  - Else ForwardAE=01 if RegWriteW and rwW==rsE.
  - Else ForwardAE=00.
  - MEM has priority over WB. ForwardBE is identical using rtE.
  - ForwardAD = RegWriteM & ~MemtoRegM & rwM==rsD. ForwardBD is identical using rtD.
- A source "matches X" when (useRsD & rsD==X) or (useRtD & rtD==X).
- lw_haz = MemtoRegE & RegWriteE & the ID sources match rwE.
- br_haz = isBranchD & ((RegWriteE & match rwE) | (MemtoRegM & match rwM)).
- A load in EX feeding a branch therefore stalls 2 cycles: one cycle via lw_haz/br_haz, then one via the MEM term.
- FSM state register, reset to RUN:
  - RUN:
    - haz = lw_haz | br_haz.
    - StallF = StallD = FlushE = haz.
    - isLWHazard = lw_haz.
    - FlushD = PCSrcD & ~haz. A stall suppresses the flush; the branch resolves in a later cycle.
    - StopW=1 takes the HALT transition on the next edge. StopW has priority over any hazard in the same cycle, but the outputs in that cycle are still the RUN values.
  - HALT:
    - StallF = StallD = FlushE = 1, FlushD = 0, isLWHazard = 0, halted = 1.
    - Forward selects keep their combinational values.
    - Only reset leaves HALT.
- Hazard decisions are re-evaluated every cycle from current inputs; no stall length is latched.
- Counters:
  - stall_cnt increments on each clock with StallD=1 while in RUN.
  - flush_cnt increments on each clock with FlushD=1.
  - Both saturate at all-ones and do not wrap.
  - Counters do not increment in HALT.
- Reset (asynchronous, any time, including mid-stall or in HALT):
  - State goes to RUN and counters to 0 immediately.
  - halted=0.
  - Control outputs follow RUN equations, i.e. 0 given quiescent inputs.
- Latency: all control outputs are combinational from current inputs and state. State and counters update on the rising clock edge.

Test Plan:
- Load-use: EX holds lw with rwE=8, RegWriteE=MemtoRegE=1; ID useRsD=1, rsD=8 -> StallF=StallD=FlushE=isLWHazard=1 for 1 cycle. Next cycle, with the load moved to MEM, the stall drops and ForwardAE=01 once the load reaches WB. stall_cnt=1.
- Forward priority: RegWriteM=1, rwM=5; RegWriteW=1, rwW=5; rsE=5 -> ForwardAE=10. Set rwM=0 -> ForwardAE=01. Set rsE=rwW=0 -> ForwardAE=00.
- Branch after load: isBranchD=1, rtD=9, useRtD=1, lw rwE=9 -> stall 2 consecutive cycles, then ForwardBD=0 (load data comes from the register file path). stall_cnt=2.
- Taken branch: PCSrcD=1, no hazard -> FlushD=1 for 1 cycle, flush_cnt=1. Same cycle with lw_haz=1 -> FlushD=0, stall asserted.
- Halt: StopW=1 for 1 cycle -> from next cycle halted=1 and StallF=StallD=FlushE=1 indefinitely. Counters frozen. Asserting reset asynchronously mid-cycle -> halted=0 and counters 0 immediately.
- Saturation with CNT_W=4: hold lw_haz for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard, stall, flush and forwarding control for the 5-stage MIPS pipeline.
// Also owns the halt sequence and saturating stall/flush debug counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             useRsD,
  input  logic             useRtD,
  input  logic             isBranchD,
  input  logic             PCSrcD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       rwE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [4:0]       rwM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [4:0]       rwW,
  input  logic             RegWriteW,
  input  logic             StopW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             isLWHazard,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, HALT} state_t;
  state_t state;

  logic match_e, match_m;
  logic lw_haz, br_haz, haz;

  // Register 0 is hardwired, so a zero destination never creates a dependency.
  assign match_e = (|rwE) && ((useRsD && (rsD == rwE)) || (useRtD && (rtD == rwE)));
  assign match_m = (|rwM) && ((useRsD && (rsD == rwM)) || (useRtD && (rtD == rwM)));

  assign lw_haz = MemtoRegE && RegWriteE && match_e;
  assign br_haz = isBranchD && ((RegWriteE && match_e) || (MemtoRegM && match_m));
  assign haz    = lw_haz || br_haz;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (|rwM) && (rwM == rsE))      ForwardAE = 2'b10;
    else if (RegWriteW && (|rwW) && (rwW == rsE)) ForwardAE = 2'b01;
    if (RegWriteM && (|rwM) && (rwM == rtE))      ForwardBE = 2'b10;
    else if (RegWriteW && (|rwW) && (rwW == rtE)) ForwardBE = 2'b01;
  end

  // Branch operands in ID can only take ALU results from MEM; load data is not ready yet.
  assign ForwardAD = RegWriteM && !MemtoRegM && (|rwM) && (rwM == rsD);
  assign ForwardBD = RegWriteM && !MemtoRegM && (|rwM) && (rwM == rtD);

  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    isLWHazard = 1'b0;
    if (state == HALT) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF     = haz;
      StallD     = haz;
      FlushE     = haz;
      isLWHazard = lw_haz;
      // A stalled branch resolves again next cycle, so its flush waits until then.
      FlushD     = PCSrcD && !haz;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (StopW) begin
            state  <= HALT;
            halted <= 1'b1;
          end
          if (StallD && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
          if (FlushD && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
        HALT: begin
          state  <= HALT;
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl: vectors feed a scoreboard queue that is
// drained and compared half a cycle later; counters and halt come from a small model.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rsD, rtD, rsE, rtE, rwE, rwM, rwW;
  logic useRsD, useRtD, isBranchD, PCSrcD;
  logic RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW, StopW;
  logic StallF, StallD, FlushD, FlushE, isLWHazard, ForwardAD, ForwardBD, halted;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
    .isBranchD(isBranchD), .PCSrcD(PCSrcD),
    .rsE(rsE), .rtE(rtE), .rwE(rwE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .rwM(rwM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .rwW(rwW), .RegWriteW(RegWriteW), .StopW(StopW),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .isLWHazard(isLWHazard), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rsD, rtD;
    logic       useRsD, useRtD, isBranchD, PCSrcD;
    logic [4:0] rsE, rtE, rwE;
    logic       RegWriteE, MemtoRegE;
    logic [4:0] rwM;
    logic       RegWriteM, MemtoRegM;
    logic [4:0] rwW;
    logic       RegWriteW, StopW;
  } in_t;

  // ctrl = {StallF, StallD, FlushD, FlushE, isLWHazard, ForwardAE, ForwardBE, ForwardAD, ForwardBD}
  typedef struct {
    string       name;
    in_t         i;
    logic [10:0] ctrl;
  } vec_t;

  typedef struct {
    string            name;
    logic [10:0]      ctrl;
    logic             halted;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic             m_halt;
  logic [CNT_W-1:0] m_sc, m_fc;

  function automatic in_t mk(
    input logic [4:0] a_rsD, a_rtD, input logic a_uRs, a_uRt, a_br, a_pc,
    input logic [4:0] a_rsE, a_rtE, a_rwE, input logic a_wE, a_mE,
    input logic [4:0] a_rwM, input logic a_wM, a_mM,
    input logic [4:0] a_rwW, input logic a_wW, a_stop);
    in_t t;
    t.rsD = a_rsD; t.rtD = a_rtD; t.useRsD = a_uRs; t.useRtD = a_uRt;
    t.isBranchD = a_br; t.PCSrcD = a_pc;
    t.rsE = a_rsE; t.rtE = a_rtE; t.rwE = a_rwE; t.RegWriteE = a_wE; t.MemtoRegE = a_mE;
    t.rwM = a_rwM; t.RegWriteM = a_wM; t.MemtoRegM = a_mM;
    t.rwW = a_rwW; t.RegWriteW = a_wW; t.StopW = a_stop;
    return t;
  endfunction

  function automatic logic [10:0] ex(
    input logic sf, sd, fd, fe, lw, input logic [1:0] fae, fbe, input logic fad, fbd);
    return {sf, sd, fd, fe, lw, fae, fbe, fad, fbd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input in_t t);
    rsD = t.rsD; rtD = t.rtD; useRsD = t.useRsD; useRtD = t.useRtD;
    isBranchD = t.isBranchD; PCSrcD = t.PCSrcD;
    rsE = t.rsE; rtE = t.rtE; rwE = t.rwE; RegWriteE = t.RegWriteE; MemtoRegE = t.MemtoRegE;
    rwM = t.rwM; RegWriteM = t.RegWriteM; MemtoRegM = t.MemtoRegM;
    rwW = t.rwW; RegWriteW = t.RegWriteW; StopW = t.StopW;
  endtask

  // One vector per clock: drive after the edge, push expectation, compare on the falling edge.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    drive(v.i);
    e.name = v.name; e.ctrl = v.ctrl; e.halted = m_halt; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    if (!m_halt) begin
      if (v.ctrl[9] && (m_sc != '1)) m_sc = m_sc + 1'b1;
      if (v.ctrl[8] && (m_fc != '1)) m_fc = m_fc + 1'b1;
      if (v.i.StopW) m_halt = 1'b1;
    end
    @(negedge clk);
    got = sb.pop_front();
    check({got.name, ".ctrl"},
          32'({StallF, StallD, FlushD, FlushE, isLWHazard, ForwardAE, ForwardBE, ForwardAD, ForwardBD}),
          32'(got.ctrl));
    check({got.name, ".halted"}, 32'(halted), 32'(got.halted));
    check({got.name, ".stall_cnt"}, 32'(stall_cnt), 32'(got.sc));
    check({got.name, ".flush_cnt"}, 32'(flush_cnt), 32'(got.fc));
  endtask

  task automatic add(input string n, input in_t t, input logic [10:0] c);
    vec_t v;
    v.name = n; v.i = t; v.ctrl = c;
    vecs.push_back(v);
  endtask

  in_t idle, lw8, taken;

  initial begin
    //          rsD rtD uRs uRt br pc  rsE rtE rwE wE mE  rwM wM mM  rwW wW stop
    idle  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
    lw8   = mk(8, 0, 1, 0, 0, 0,  0, 0, 8, 1, 1,  0, 0, 0,  0, 0, 0);
    taken = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);

    add("idle",        idle, ex(0,0,0,0,0,2'b00,2'b00,0,0));
    add("lu_stall",    lw8,  ex(1,1,0,1,1,2'b00,2'b00,0,0));
    add("lu_mem",      mk(8,0,1,0,0,0, 0,0,0,0,0, 8,1,1, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,0,0));
    add("lu_wb",       mk(0,0,0,0,0,0, 8,0,0,0,0, 0,0,0, 8,1,0), ex(0,0,0,0,0,2'b01,2'b00,0,0));
    add("fwd_mem_pri", mk(0,0,0,0,0,0, 5,0,0,0,0, 5,1,0, 5,1,0), ex(0,0,0,0,0,2'b10,2'b00,0,0));
    add("fwd_wb",      mk(0,0,0,0,0,0, 5,0,0,0,0, 0,1,0, 5,1,0), ex(0,0,0,0,0,2'b01,2'b00,0,0));
    add("fwd_r0",      mk(0,0,0,0,0,0, 0,0,0,0,0, 0,1,0, 0,1,0), ex(0,0,0,0,0,2'b00,2'b00,0,0));
    add("fwd_b_wb",    mk(0,0,0,0,0,0, 0,3,0,0,0, 4,1,0, 3,1,0), ex(0,0,0,0,0,2'b00,2'b01,0,0));
    add("fwd_ad",      mk(6,7,0,0,0,0, 0,0,0,0,0, 6,1,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,1,0));
    add("fwd_bd_load", mk(6,7,0,0,0,0, 0,0,0,0,0, 7,1,1, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,0,0));
    add("fwd_bd",      mk(6,7,0,0,0,0, 0,0,0,0,0, 7,1,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,0,1));
    add("br_lw1",      mk(0,9,0,1,1,0, 0,0,9,1,1, 0,0,0, 0,0,0), ex(1,1,0,1,1,2'b00,2'b00,0,0));
    add("br_lw2",      mk(0,9,0,1,1,0, 0,0,0,0,0, 9,1,1, 0,0,0), ex(1,1,0,1,0,2'b00,2'b00,0,0));
    add("br_lw3",      mk(0,9,0,1,1,0, 0,0,0,0,0, 0,0,0, 9,1,0), ex(0,0,0,0,0,2'b00,2'b00,0,0));
    add("br_alu",      mk(10,0,1,0,1,0, 0,0,10,1,0, 0,0,0, 0,0,0), ex(1,1,0,1,0,2'b00,2'b00,0,0));
    add("br_r0",       mk(0,0,1,0,1,0, 0,0,0,1,1, 0,0,0, 0,0,0), ex(0,0,0,0,0,2'b00,2'b00,0,0));
    add("taken",       taken, ex(0,0,1,0,0,2'b00,2'b00,0,0));
    add("taken_lw",    mk(8,0,1,0,0,1, 0,0,8,1,1, 0,0,0, 0,0,0), ex(1,1,0,1,1,2'b00,2'b00,0,0));
    add("stop_lw",     mk(8,0,1,0,0,0, 0,0,8,1,1, 0,0,0, 0,0,1), ex(1,1,0,1,1,2'b00,2'b00,0,0));
    add("halt_idle",   idle, ex(1,1,0,1,0,2'b00,2'b00,0,0));
    add("halt_busy",   mk(8,0,1,0,0,1, 5,0,8,1,1, 5,1,0, 0,0,0), ex(1,1,0,1,0,2'b10,2'b00,0,0));
    add("halt_idle2",  idle, ex(1,1,0,1,0,2'b00,2'b00,0,0));

    reset = 1'b1;
    drive(idle);
    m_halt = 1'b0; m_sc = '0; m_fc = '0;
    #3;
    check("reset.ctrl", 32'({StallF, StallD, FlushD, FlushE, isLWHazard}), 32'd0);
    check("reset.halted", 32'(halted), 32'd0);
    check("reset.counters", 32'({stall_cnt, flush_cnt}), 32'd0);
    #1 reset = 1'b0;

    foreach (vecs[k]) apply(vecs[k]);

    // Asynchronous reset in the middle of a cycle while halted.
    #2 reset = 1'b1;
    #1;
    check("async_rst.halted", 32'(halted), 32'd0);
    check("async_rst.stall_cnt", 32'(stall_cnt), 32'd0);
    check("async_rst.flush_cnt", 32'(flush_cnt), 32'd0);
    check("async_rst.ctrl", 32'({StallF, StallD, FlushD, FlushE, isLWHazard}), 32'd0);
    #1 reset = 1'b0;
    m_halt = 1'b0; m_sc = '0; m_fc = '0;

    begin
      vec_t v;
      v.name = "sat_stall"; v.i = lw8; v.ctrl = ex(1,1,0,1,1,2'b00,2'b00,0,0);
      for (int n = 0; n < 20; n++) apply(v);
      v.name = "sat_flush"; v.i = taken; v.ctrl = ex(0,0,1,0,0,2'b00,2'b00,0,0);
      for (int n = 0; n < 20; n++) apply(v);
      v.name = "sat_final"; v.i = idle; v.ctrl = ex(0,0,0,0,0,2'b00,2'b00,0,0);
      apply(v);
    end
    check("sat.stall_cnt", 32'(stall_cnt), 32'd15);
    check("sat.flush_cnt", 32'(flush_cnt), 32'd15);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
